// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: parameter defaults, read-response
// FSM encoding and the starvation-counter width helper.
package dmem_pkg;

    localparam int unsigned DefAddrW       = 32;
    localparam int unsigned DefDataW       = 32;
    localparam int unsigned DefStarveLimit = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRdCpu = 2'd1,
        StRdDma = 2'd2
    } rd_state_e;

    // Counter must hold 0..limit; a zero limit still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU, DMA and RAM-side signals around the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  ram_rdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output ram_addr, ram_wdata, ram_we, ram_re
    );

    // Requesters plus RAM.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output ram_rdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  ram_addr, ram_wdata, ram_we, ram_re
    );

endinterface

// File: rtl/dmem_prio.sv
// Fixed CPU-first priority with a starvation override that lets DMA through once
// the CPU has won STARVE_LIMIT contested cycles in a row.
module dmem_prio
    import dmem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DefStarveLimit,
    parameter int unsigned CntW         = cnt_width(STARVE_LIMIT)
) (
    input  logic            cpu_req_i,
    input  logic            dma_req_i,
    input  logic [CntW-1:0] starve_cnt_i,
    output logic            cpu_gnt_o,
    output logic            dma_gnt_o
);

    logic starved;

    always_comb begin
        starved   = (starve_cnt_i == CntW'(STARVE_LIMIT));
        cpu_gnt_o = cpu_req_i & ~(dma_req_i & starved);
        dma_gnt_o = dma_req_i & (~cpu_req_i | starved);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU MEM stage and a DMA/debug port.
// Grants are combinational; read data is routed back one cycle later to its owner.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W       = DefAddrW,
    parameter int unsigned DATA_W       = DefDataW,
    parameter int unsigned STARVE_LIMIT = DefStarveLimit
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave mem_io
);

    localparam int unsigned CntW = cnt_width(STARVE_LIMIT);

    logic            cpu_req_v, dma_req_v;
    logic            cpu_gnt, dma_gnt;
    logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
    rd_state_e       rd_state_q, rd_state_d;
    logic            cpu_rvalid_q, dma_rvalid_q;

    // Requests are masked during reset so nothing reaches the RAM.
    assign cpu_req_v = mem_io.cpu_req & ~rst;
    assign dma_req_v = mem_io.dma_req & ~rst;

    dmem_prio #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CntW         (CntW)
    ) u_prio (
        .cpu_req_i    (cpu_req_v),
        .dma_req_i    (dma_req_v),
        .starve_cnt_i (starve_cnt_q),
        .cpu_gnt_o    (cpu_gnt),
        .dma_gnt_o    (dma_gnt)
    );

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (dma_gnt) begin
            starve_cnt_d = '0;
        end else if (cpu_gnt && dma_req_v && (starve_cnt_q != CntW'(STARVE_LIMIT))) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end

        rd_state_d = StIdle;
        if (cpu_gnt && !mem_io.cpu_we) begin
            rd_state_d = StRdCpu;
        end else if (dma_gnt && !mem_io.dma_we) begin
            rd_state_d = StRdDma;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q   <= StIdle;
            starve_cnt_q <= '0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
        end else begin
            rd_state_q   <= rd_state_d;
            starve_cnt_q <= starve_cnt_d;
            cpu_rvalid_q <= (rd_state_d == StRdCpu);
            dma_rvalid_q <= (rd_state_d == StRdDma);
        end
    end

    always_comb begin
        mem_io.cpu_gnt   = cpu_gnt;
        mem_io.dma_gnt   = dma_gnt;
        mem_io.cpu_stall = mem_io.cpu_req & ~cpu_gnt;

        mem_io.ram_addr  = '0;
        mem_io.ram_wdata = '0;
        mem_io.ram_we    = 1'b0;
        mem_io.ram_re    = 1'b0;
        if (cpu_gnt) begin
            mem_io.ram_addr  = mem_io.cpu_addr;
            mem_io.ram_wdata = mem_io.cpu_wdata;
            mem_io.ram_we    = mem_io.cpu_we;
            mem_io.ram_re    = ~mem_io.cpu_we;
        end else if (dma_gnt) begin
            mem_io.ram_addr  = mem_io.dma_addr;
            mem_io.ram_wdata = mem_io.dma_wdata;
            mem_io.ram_we    = mem_io.dma_we;
            mem_io.ram_re    = ~mem_io.dma_we;
        end

        // A response still in flight when reset hits is suppressed immediately.
        mem_io.cpu_rvalid = cpu_rvalid_q & ~rst;
        mem_io.dma_rvalid = dma_rvalid_q & ~rst;
        mem_io.cpu_rdata  = (rd_state_q == StRdCpu && !rst) ? mem_io.ram_rdata : '0;
        mem_io.dma_rdata  = (rd_state_q == StRdDma && !rst) ? mem_io.ram_rdata : '0;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, RAM byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, RAM data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive contested CPU wins before DMA is forced through.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 cpu_req  input  1  MEM-stage access request; held until granted.
REQ-007 cpu_we  input  1  CPU store (1) / load (0).
REQ-008 cpu_addr  input  ADDR_W  CPU address (ALU result).
REQ-009 cpu_wdata  input  DATA_W  CPU store data (post-forwarding).
REQ-010 cpu_gnt  output  1  CPU access accepted this cycle.
REQ-011 cpu_stall  output  1  freeze pipeline: cpu_req & ~cpu_gnt.
REQ-012 cpu_rvalid  output  1  CPU load data valid.
REQ-013 cpu_rdata  output  DATA_W  CPU load data.
REQ-014 dma_req  input  1  loader/debug request; held until granted.
REQ-015 dma_we  input  1  DMA write (1) / read (0).
REQ-016 dma_addr  input  ADDR_W  DMA address.
REQ-017 dma_wdata  input  DATA_W  DMA write data.
REQ-018 dma_gnt  output  1  DMA access accepted this cycle.
REQ-019 dma_rvalid  output  1  DMA read data valid.
REQ-020 dma_rdata  output  DATA_W  DMA read data.
REQ-021 ram_addr / ram_wdata  output  ADDR_W / DATA_W  to RAM, from granted requester, else 0.
REQ-022 ram_we / ram_re  output  1 each  RAM write / read enable.
REQ-023 ram_rdata  input  DATA_W  RAM read data, valid one cycle after ram_re.

Function
REQ-024 Grant SHALL be combinational, same cycle as req; at most one gnt high per cycle; no gnt without req.
REQ-025 Priority: CPU wins contention unless starve_cnt == STARVE_LIMIT, in which case DMA wins.
REQ-026 starve_cnt SHALL increment when both req high and CPU granted, saturating at STARVE_LIMIT; clear when DMA granted; hold otherwise.
REQ-027 ram_we = gnt & we, ram_re = gnt & ~we of granted requester; both 0 with no grant.
REQ-028 Read-response FSM states IDLE, RD_CPU, RD_DMA, updated every cycle: next = RD_CPU on CPU read grant, RD_DMA on DMA read grant, else IDLE; back-to-back reads SHALL be supported at one per cycle.
REQ-029 In RD_CPU: cpu_rvalid=1, cpu_rdata=ram_rdata; in RD_DMA: dma_rvalid=1, dma_rdata=ram_rdata; non-owner rvalid=0, rdata=0; IDLE: both 0.
REQ-030 Read latency SHALL be exactly 1 cycle from gnt to rvalid; writes SHALL produce no rvalid.
REQ-031 Same-address write and read from different requesters SHALL be serialized in grant order; read after granted write returns the new data.

Reset
REQ-032 While rst=1: gnts 0, ram_we/ram_re 0, cpu_stall = cpu_req; next edge leaves state IDLE, starve_cnt 0, rvalids 0.
REQ-033 Reset asserted with a read outstanding SHALL drop its response (no rvalid after reset).

Structure
REQ-034 FSM state encoding and default parameter values SHALL live in shared package dmem_pkg.
REQ-035 Priority/starvation logic SHALL be sub-module dmem_prio (req pair + starve_cnt -> grant pair); RAM stays external.

Verification
REQ-036 CPU read addr 0x10 (RAM holds 0xDEADBEEF), no DMA -> cpu_gnt same cycle, cpu_rvalid next cycle with 0xDEADBEEF, cpu_stall 0.
REQ-037 Both req continuously, CPU reads, STARVE_LIMIT=4 -> CPU granted 4 cycles, DMA on 5th with cpu_stall=1, cycle repeats.
REQ-038 DMA write 0x20<-0x12345678, CPU read 0x20 next cycle -> cpu_rdata 0x12345678.
REQ-039 Alternating CPU/DMA reads every cycle -> rvalid routed to correct owner each cycle, never both high.
REQ-040 CPU read granted, rst asserted next cycle -> no cpu_rvalid, starve_cnt 0, gnts 0 during rst.
